// File: rtl/xrv_i_fetch_align_pkg.sv
`default_nettype none
// ============================================================================
// xrv_i_fetch_align_pkg: opcode, funct3 and quadrant constants for the aligner
// Rev 1.0
// ============================================================================
package xrv_i_fetch_align_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_SRL = 3'b101;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   // Compressed funct3 codes; any code not listed for a quadrant is illegal on RV32C without F/D.
   localparam logic [2:0] CF3_C0_ADDI4SPN = 3'b000;
   localparam logic [2:0] CF3_C0_LW       = 3'b010;
   localparam logic [2:0] CF3_C0_SW       = 3'b110;
   localparam logic [2:0] CF3_C1_ADDI     = 3'b000;
   localparam logic [2:0] CF3_C1_JAL      = 3'b001;
   localparam logic [2:0] CF3_C1_LI       = 3'b010;
   localparam logic [2:0] CF3_C1_LUI      = 3'b011;
   localparam logic [2:0] CF3_C1_ALU      = 3'b100;
   localparam logic [2:0] CF3_C1_J        = 3'b101;
   localparam logic [2:0] CF3_C1_BEQZ     = 3'b110;
   localparam logic [2:0] CF3_C1_BNEZ     = 3'b111;
   localparam logic [2:0] CF3_C2_SLLI     = 3'b000;
   localparam logic [2:0] CF3_C2_LWSP     = 3'b010;
   localparam logic [2:0] CF3_C2_JR       = 3'b100;
   localparam logic [2:0] CF3_C2_SWSP     = 3'b110;

   typedef enum logic [1:0] {
      QUAD_C0 = 2'b00,
      QUAD_C1 = 2'b01,
      QUAD_C2 = 2'b10,
      QUAD_32 = 2'b11
   } quad_e;

   function automatic logic is_hw32(input logic [15:0] hw);
      return hw[1:0] == 2'b11;
   endfunction

endpackage
`default_nettype wire

// File: rtl/xrv_i_fetch_align_rvc_expand.sv
`default_nettype none
// ============================================================================
// xrv_i_rvc_expand: combinational RV32C to RV32I expander with illegal flag
// Rev 1.0
// ============================================================================
module xrv_i_rvc_expand
   import xrv_i_fetch_align_pkg::*;
#(
   parameter bit C_EN = 1'b1
) (
   input  logic [15:0] instr_i,
   output logic [31:0] instr_o,
   output logic        illegal_o
);

   generate
      if (C_EN) begin : g_rvc
         logic [15:0] hw;
         quad_e       quad;
         logic [2:0]  f3;
         logic [4:0]  rd;
         logic [4:0]  rs2;
         logic [4:0]  rdp;
         logic [4:0]  rs1p;
         logic [31:0] exp_instr;
         logic        exp_ill;

         assign hw   = instr_i;
         assign quad = quad_e'(hw[1:0]);
         assign f3   = hw[15:13];
         assign rd   = hw[11:7];
         assign rs2  = hw[6:2];
         assign rdp  = {2'b01, hw[4:2]};
         assign rs1p = {2'b01, hw[9:7]};

         always_comb begin
            exp_instr = 32'h0;
            exp_ill   = 1'b0;
            case (quad)
               QUAD_C0: begin
                  case (f3)
                     CF3_C0_ADDI4SPN: begin
                        exp_ill   = (hw[12:5] == 8'h00);
                        exp_instr = {2'b00, hw[10:7], hw[12:11], hw[5], hw[6], 2'b00,
                                     5'd2, F3_ADD, rdp, OP_IMM};
                     end
                     CF3_C0_LW:
                        exp_instr = {5'b0, hw[5], hw[12:10], hw[6], 2'b00,
                                     rs1p, F3_LW, rdp, OP_LOAD};
                     CF3_C0_SW:
                        exp_instr = {5'b0, hw[5], hw[12], rdp, rs1p, F3_LW,
                                     hw[11:10], hw[6], 2'b00, OP_STORE};
                     default: exp_ill = 1'b1;
                  endcase
               end
               QUAD_C1: begin
                  case (f3)
                     CF3_C1_ADDI:
                        exp_instr = {{7{hw[12]}}, hw[6:2], rd, F3_ADD, rd, OP_IMM};
                     CF3_C1_JAL, CF3_C1_J:
                        exp_instr = {hw[12], hw[8], hw[10:9], hw[6], hw[7], hw[2], hw[11],
                                     hw[5:3], hw[12], {8{hw[12]}},
                                     (f3 == CF3_C1_JAL) ? 5'd1 : 5'd0, OP_JAL};
                     CF3_C1_LI:
                        exp_instr = {{7{hw[12]}}, hw[6:2], 5'd0, F3_ADD, rd, OP_IMM};
                     CF3_C1_LUI: begin
                        exp_ill = ({hw[12], hw[6:2]} == 6'h00);
                        if (rd == 5'd2) begin
                           exp_instr = {{3{hw[12]}}, hw[4:3], hw[5], hw[2], hw[6], 4'b0000,
                                        5'd2, F3_ADD, 5'd2, OP_IMM};
                        end else begin
                           exp_instr = {{15{hw[12]}}, hw[6:2], rd, OP_LUI};
                        end
                     end
                     CF3_C1_ALU: begin
                        case (hw[11:10])
                           2'b00: begin
                              exp_ill   = hw[12];
                              exp_instr = {7'b0000000, hw[6:2], rs1p, F3_SRL, rs1p, OP_IMM};
                           end
                           2'b01: begin
                              exp_ill   = hw[12];
                              exp_instr = {7'b0100000, hw[6:2], rs1p, F3_SRL, rs1p, OP_IMM};
                           end
                           2'b10:
                              exp_instr = {{7{hw[12]}}, hw[6:2], rs1p, F3_AND, rs1p, OP_IMM};
                           default: begin
                              // bit 12 set selects c.subw/c.addw and reserved codes
                              exp_ill = hw[12];
                              case (hw[6:5])
                                 2'b00:   exp_instr = {7'b0100000, rdp, rs1p, F3_ADD, rs1p, OP_REG};
                                 2'b01:   exp_instr = {7'b0000000, rdp, rs1p, F3_XOR, rs1p, OP_REG};
                                 2'b10:   exp_instr = {7'b0000000, rdp, rs1p, F3_OR, rs1p, OP_REG};
                                 default: exp_instr = {7'b0000000, rdp, rs1p, F3_AND, rs1p, OP_REG};
                              endcase
                           end
                        endcase
                     end
                     CF3_C1_BEQZ, CF3_C1_BNEZ:
                        exp_instr = {{4{hw[12]}}, hw[6:5], hw[2], 5'd0, rs1p,
                                     (f3 == CF3_C1_BEQZ) ? F3_BEQ : F3_BNE,
                                     hw[11:10], hw[4:3], hw[12], OP_BRANCH};
                     default: exp_ill = 1'b1;
                  endcase
               end
               QUAD_C2: begin
                  case (f3)
                     CF3_C2_SLLI: begin
                        exp_ill   = hw[12];
                        exp_instr = {7'b0000000, hw[6:2], rd, F3_SLL, rd, OP_IMM};
                     end
                     CF3_C2_LWSP: begin
                        exp_ill   = (rd == 5'd0);
                        exp_instr = {4'b0000, hw[3:2], hw[12], hw[6:4], 2'b00,
                                     5'd2, F3_LW, rd, OP_LOAD};
                     end
                     CF3_C2_JR: begin
                        if (!hw[12]) begin
                           if (rs2 == 5'd0) begin
                              exp_ill   = (rd == 5'd0);
                              exp_instr = {12'h000, rd, F3_ADD, 5'd0, OP_JALR};
                           end else begin
                              exp_instr = {7'b0000000, rs2, 5'd0, F3_ADD, rd, OP_REG};
                           end
                        end else if (rs2 == 5'd0) begin
                           exp_instr = (rd == 5'd0) ? INSTR_EBREAK
                                                    : {12'h000, rd, F3_ADD, 5'd1, OP_JALR};
                        end else begin
                           exp_instr = {7'b0000000, rs2, rd, F3_ADD, rd, OP_REG};
                        end
                     end
                     CF3_C2_SWSP:
                        exp_instr = {4'b0000, hw[8:7], hw[12], rs2, 5'd2, F3_LW,
                                     hw[11:9], 2'b00, OP_STORE};
                     default: exp_ill = 1'b1;
                  endcase
               end
               default: exp_ill = 1'b1;
            endcase
         end

         assign instr_o   = exp_ill ? {16'h0000, instr_i} : exp_instr;
         assign illegal_o = exp_ill;
      end else begin : g_no_rvc
         assign instr_o   = {16'h0000, instr_i};
         assign illegal_o = 1'b1;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/xrv_i_fetch_align.sv
`default_nettype none
// ============================================================================
// xrv_i_fetch_align: halfword buffer aligning fetch words into instructions
// Rev 1.0
// ============================================================================
module xrv_i_fetch_align
   import xrv_i_fetch_align_pkg::*;
#(
   parameter int          DEPTH_HW = 6,
   parameter bit          C_EN     = 1'b1,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   input  logic        fetch_valid_i,
   output logic        fetch_ready_o,
   input  logic [31:0] fetch_data_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_c_o,
   output logic        instr_illegal_o
);

   localparam int PTR_W = $clog2(DEPTH_HW);
   localparam int CNT_W = $clog2(DEPTH_HW + 1);
   localparam logic [PTR_W:0]   DEPTH_S     = (PTR_W + 1)'(DEPTH_HW);
   localparam logic [CNT_W-1:0] CNT_RDY_MAX = CNT_W'(DEPTH_HW - 2);

   logic [15:0]      hbuf_q [DEPTH_HW];
   logic [PTR_W-1:0] head_q, head_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      pc_q, pc_d;
   logic             skip_q, skip_d;

   logic [15:0]      head_hw;
   logic [15:0]      next_hw;
   logic             head_32;
   logic             push;
   logic             pop;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] tail_p1;
   logic [CNT_W-1:0] push_hw;
   logic [CNT_W-1:0] pop_hw;
   logic [31:0]      exp_instr;
   logic             exp_ill;
   logic             unused_flush_pc_lsb;

   // Circular add; the sum never reaches twice the depth, so one subtraction wraps it.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                input logic [CNT_W-1:0] n);
      logic [PTR_W:0] s;
      s = {1'b0, p} + (PTR_W + 1)'(n);
      if (s >= DEPTH_S) begin
         s = s - DEPTH_S;
      end
      return s[PTR_W-1:0];
   endfunction

   assign unused_flush_pc_lsb = flush_pc_i[0];

   assign head_hw = hbuf_q[head_q];
   assign next_hw = hbuf_q[ptr_add(head_q, CNT_W'(1))];
   assign head_32 = is_hw32(head_hw);
   assign tail    = ptr_add(head_q, count_q);
   assign tail_p1 = ptr_add(tail, CNT_W'(1));

   assign fetch_ready_o = (count_q <= CNT_RDY_MAX);
   assign instr_valid_o = !flush_i &&
                          ((count_q >= CNT_W'(2)) || ((count_q == CNT_W'(1)) && !head_32));
   assign push          = fetch_valid_i && fetch_ready_o && !flush_i;
   assign pop           = instr_valid_o && instr_ready_i;
   assign push_hw       = skip_q ? CNT_W'(1) : CNT_W'(2);
   assign pop_hw        = head_32 ? CNT_W'(2) : CNT_W'(1);

   xrv_i_rvc_expand #(
      .C_EN (C_EN)
   ) u_rvc_expand (
      .instr_i   (head_hw),
      .instr_o   (exp_instr),
      .illegal_o (exp_ill)
   );

   assign instr_o         = head_32 ? {next_hw, head_hw} : exp_instr;
   assign instr_pc_o      = pc_q;
   assign instr_c_o       = !head_32;
   assign instr_illegal_o = !head_32 && exp_ill;

   always_comb begin
      head_d  = head_q;
      count_d = count_q;
      pc_d    = pc_q;
      skip_d  = skip_q;
      if (flush_i) begin
         count_d = '0;
         pc_d    = {flush_pc_i[31:1], 1'b0};
         skip_d  = flush_pc_i[1];
      end else begin
         if (pop) begin
            head_d = ptr_add(head_q, pop_hw);
            pc_d   = pc_q + (head_32 ? 32'd4 : 32'd2);
         end
         count_d = count_q + (push ? push_hw : '0) - (pop ? pop_hw : '0);
         if (push) begin
            skip_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q  <= '0;
         count_q <= '0;
         pc_q    <= {RESET_PC[31:1], 1'b0};
         skip_q  <= RESET_PC[1];
      end else begin
         head_q  <= head_d;
         count_q <= count_d;
         pc_q    <= pc_d;
         skip_q  <= skip_d;
      end
   end

   // Payload storage needs no reset: entries beyond count are never presented as valid.
   always_ff @(posedge clk) begin
      if (push) begin
         if (skip_q) begin
            hbuf_q[tail] <= fetch_data_i[31:16];
         end else begin
            hbuf_q[tail]    <= fetch_data_i[15:0];
            hbuf_q[tail_p1] <= fetch_data_i[31:16];
         end
      end
   end

endmodule
`default_nettype wire
